// File: rtl/odma_lite_regs_pkg.sv
// Shared constants for the ODMA action AXI-lite register file: register map,
// CTRL/STATUS bit positions, response codes and a byte-lane merge helper.
package odma_lite_regs_pkg;

    localparam int REG_ID       = 0;
    localparam int REG_CTRL     = 1;
    localparam int REG_STATUS   = 2;
    localparam int REG_CYCLES   = 3;
    localparam int REG_SCRATCH0 = 4;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge sized for the widest supported bus; callers cast to their width.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/odma_lite_wr_join.sv
// AXI-lite write join: captures AW and W independently, issues one register
// write once both are held, and owns the B handshake.
module odma_lite_wr_join #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ADDR_LSB = 2,
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_lite_awvalid,
    input  logic [AW-1:0]    s_lite_awaddr,
    output logic             s_lite_awready,
    input  logic             s_lite_wvalid,
    input  logic [DW-1:0]    s_lite_wdata,
    input  logic [DW/8-1:0]  s_lite_wstrb,
    output logic             s_lite_wready,
    output logic             s_lite_bvalid,
    output logic [1:0]       s_lite_bresp,
    input  logic             s_lite_bready,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic             o_wr_addr_ok,
    output logic [DW-1:0]    o_wr_data,
    output logic [DW/8-1:0]  o_wr_strb,
    input  logic             i_wr_err
);
    import odma_lite_regs_pkg::*;

    logic                 r_aw_held;
    logic [AW-1:ADDR_LSB] r_aw_addr;
    logic                 r_w_held;
    logic [DW-1:0]        r_w_data;
    logic [DW/8-1:0]      r_w_strb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;

    logic w_aw_acc;
    logic w_w_acc;
    logic w_b_acc;
    logic w_unused_awaddr_lsb;

    assign s_lite_awready = ~r_aw_held & ~r_bvalid;
    assign s_lite_wready  = ~r_w_held & ~r_bvalid;
    assign s_lite_bvalid  = r_bvalid;
    assign s_lite_bresp   = r_bresp;

    assign w_aw_acc = s_lite_awvalid & s_lite_awready;
    assign w_w_acc  = s_lite_wvalid & s_lite_wready;
    assign w_b_acc  = r_bvalid & s_lite_bready;

    assign w_unused_awaddr_lsb = ^s_lite_awaddr[ADDR_LSB-1:0];

    // Fires for exactly one cycle: bvalid rises on the same edge and blocks a repeat.
    assign o_wr_en      = r_aw_held & r_w_held & ~r_bvalid;
    assign o_wr_idx     = r_aw_addr[ADDR_LSB +: IDX_W];
    assign o_wr_addr_ok = (r_aw_addr[AW-1:ADDR_LSB+IDX_W] == '0) &&
                          ({1'b0, o_wr_idx} < (IDX_W+1)'(NUM_REGS));
    assign o_wr_data    = r_w_data;
    assign o_wr_strb    = r_w_strb;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_acc) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_lite_awaddr[AW-1:ADDR_LSB];
            end else if (w_b_acc) begin
                r_aw_held <= 1'b0;
            end

            if (w_w_acc) begin
                r_w_held <= 1'b1;
                r_w_data <= s_lite_wdata;
                r_w_strb <= s_lite_wstrb;
            end else if (w_b_acc) begin
                r_w_held <= 1'b0;
            end

            if (o_wr_en) begin
                r_bvalid <= 1'b1;
                r_bresp  <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (w_b_acc) begin
                r_bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/odma_action_lite_regs.sv
// AXI-lite register file for ODMA unit-sim actions: ID, CTRL start/irq_en,
// STATUS busy/done, busy-cycle counter, byte-strobed scratch registers.
module odma_action_lite_regs #(
    parameter int          AXIL_ADDR_WIDTH = 32,
    parameter int          AXIL_DATA_WIDTH = 32,
    parameter int          NUM_REGS        = 16,
    parameter logic [31:0] ACTION_ID       = 32'h1014_0ACE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_lite_awvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_lite_awaddr,
    output logic                         s_lite_awready,
    input  logic                         s_lite_wvalid,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_lite_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_lite_wstrb,
    output logic                         s_lite_wready,
    output logic                         s_lite_bvalid,
    output logic [1:0]                   s_lite_bresp,
    input  logic                         s_lite_bready,
    input  logic                         s_lite_arvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_lite_araddr,
    output logic                         s_lite_arready,
    output logic                         s_lite_rvalid,
    output logic [AXIL_DATA_WIDTH-1:0]   s_lite_rdata,
    output logic [1:0]                   s_lite_rresp,
    input  logic                         s_lite_rready,
    output logic                         action_start,
    input  logic                         action_done,
    output logic                         irq
);
    import odma_lite_regs_pkg::*;

    localparam int AW       = AXIL_ADDR_WIDTH;
    localparam int DW       = AXIL_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = $clog2(NUM_REGS);

    localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(REG_ID);
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(REG_CTRL);
    localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(REG_STATUS);
    localparam logic [IDX_W-1:0] IDX_CYCLES  = IDX_W'(REG_CYCLES);
    localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(REG_SCRATCH0);

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_wr_addr_ok;
    logic [DW-1:0]    w_wr_data;
    logic [SW-1:0]    w_wr_strb;
    logic             w_wr_err;
    logic             w_wr_ok;
    logic             w_start;

    logic             r_irq_en;
    logic             r_busy;
    logic             r_done;
    logic [DW-1:0]    r_cycles;
    logic             r_action_start;
    logic             r_irq;
    logic [DW-1:0]    r_scratch [REG_SCRATCH0:NUM_REGS-1];

    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic [1:0]       r_rresp;
    logic             r_rd_status;

    logic             w_ar_acc;
    logic             w_r_acc;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_ok;
    logic [DW-1:0]    w_rd_word;
    logic             w_unused_araddr_lsb;

    odma_lite_wr_join #(
        .AW       (AW),
        .DW       (DW),
        .ADDR_LSB (ADDR_LSB),
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_join (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_lite_awvalid (s_lite_awvalid),
        .s_lite_awaddr  (s_lite_awaddr),
        .s_lite_awready (s_lite_awready),
        .s_lite_wvalid  (s_lite_wvalid),
        .s_lite_wdata   (s_lite_wdata),
        .s_lite_wstrb   (s_lite_wstrb),
        .s_lite_wready  (s_lite_wready),
        .s_lite_bvalid  (s_lite_bvalid),
        .s_lite_bresp   (s_lite_bresp),
        .s_lite_bready  (s_lite_bready),
        .o_wr_en        (w_wr_en),
        .o_wr_idx       (w_wr_idx),
        .o_wr_addr_ok   (w_wr_addr_ok),
        .o_wr_data      (w_wr_data),
        .o_wr_strb      (w_wr_strb),
        .i_wr_err       (w_wr_err)
    );

    assign w_wr_err = ~w_wr_addr_ok | (w_wr_idx == IDX_ID);
    assign w_wr_ok  = w_wr_en & ~w_wr_err;
    assign w_start  = w_wr_ok & (w_wr_idx == IDX_CTRL) & w_wr_strb[0] &
                      w_wr_data[CTRL_START_BIT];

    assign action_start = r_action_start;
    assign irq          = r_irq;

    // Start outranks a coincident done for busy; done itself is set either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_cycles       <= '0;
            r_action_start <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_action_start <= w_start;
            r_irq          <= r_done & r_irq_en;

            if (w_wr_ok && w_wr_idx == IDX_CTRL && w_wr_strb[0])
                r_irq_en <= w_wr_data[CTRL_IRQ_EN_BIT];

            if (w_start)          r_busy <= 1'b1;
            else if (action_done) r_busy <= 1'b0;

            if (action_done)  r_done <= 1'b1;
            else if (w_r_acc && r_rd_status) r_done <= 1'b0;

            if (w_start)                        r_cycles <= '0;
            else if (r_busy && r_cycles != '1) r_cycles <= r_cycles + 1'b1;
        end
    end

    // NOTE: the scratch array is reset like any other flop because software expects it to read 0 after reset; it is too small to be RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) r_scratch[i] <= '0;
        end else begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                if (w_wr_ok && w_wr_idx == IDX_W'(i))
                    r_scratch[i] <= DW'(strb_merge(64'(r_scratch[i]), 64'(w_wr_data),
                                                   8'(w_wr_strb)));
            end
        end
    end

    assign w_ar_acc = s_lite_arvalid & ~r_rvalid;
    assign w_r_acc  = r_rvalid & s_lite_rready;
    assign w_rd_idx = s_lite_araddr[ADDR_LSB +: IDX_W];
    assign w_rd_ok  = (s_lite_araddr[AW-1:ADDR_LSB+IDX_W] == '0) &&
                      ({1'b0, w_rd_idx} < (IDX_W+1)'(NUM_REGS));
    assign w_unused_araddr_lsb = ^s_lite_araddr[ADDR_LSB-1:0];

    assign s_lite_arready = ~r_rvalid;
    assign s_lite_rvalid  = r_rvalid;
    assign s_lite_rdata   = r_rdata;
    assign s_lite_rresp   = r_rresp;

    // NOTE: every signal driven in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_idx == IDX_ID) begin
            w_rd_word = DW'(ACTION_ID);
        end else if (w_rd_idx == IDX_CTRL) begin
            w_rd_word[CTRL_IRQ_EN_BIT] = r_irq_en;
        end else if (w_rd_idx == IDX_STATUS) begin
            w_rd_word[STATUS_BUSY_BIT] = r_busy;
            w_rd_word[STATUS_DONE_BIT] = r_done;
        end else if (w_rd_idx == IDX_CYCLES) begin
            w_rd_word = r_cycles;
        end else if (w_rd_idx >= IDX_SCRATCH && w_rd_ok) begin
            w_rd_word = r_scratch[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_rd_status <= 1'b0;
        end else if (w_ar_acc) begin
            r_rvalid    <= 1'b1;
            r_rdata     <= w_rd_ok ? w_rd_word : '0;
            r_rresp     <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rd_status <= w_rd_ok && (w_rd_idx == IDX_STATUS);
        end else if (w_r_acc) begin
            r_rvalid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_odma_action_lite_regs.sv
// Self-checking bench for odma_action_lite_regs: directed handshake/timing cases
// plus randomized register traffic checked against a behavioural register model.
module tb_odma_action_lite_regs;
    import odma_lite_regs_pkg::*;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam int          SW = DW / 8;
    localparam int          NR = 16;
    localparam logic [31:0] ID = 32'h1014_0ACE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_lite_awvalid, s_lite_awready;
    logic [AW-1:0] s_lite_awaddr;
    logic          s_lite_wvalid, s_lite_wready;
    logic [DW-1:0] s_lite_wdata;
    logic [SW-1:0] s_lite_wstrb;
    logic          s_lite_bvalid, s_lite_bready;
    logic [1:0]    s_lite_bresp;
    logic          s_lite_arvalid, s_lite_arready;
    logic [AW-1:0] s_lite_araddr;
    logic          s_lite_rvalid, s_lite_rready;
    logic [DW-1:0] s_lite_rdata;
    logic [1:0]    s_lite_rresp;
    logic          action_start, action_done, irq;

    odma_action_lite_regs #(
        .AXIL_ADDR_WIDTH (AW),
        .AXIL_DATA_WIDTH (DW),
        .NUM_REGS        (NR),
        .ACTION_ID       (ID)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_lite_awvalid (s_lite_awvalid),
        .s_lite_awaddr  (s_lite_awaddr),
        .s_lite_awready (s_lite_awready),
        .s_lite_wvalid  (s_lite_wvalid),
        .s_lite_wdata   (s_lite_wdata),
        .s_lite_wstrb   (s_lite_wstrb),
        .s_lite_wready  (s_lite_wready),
        .s_lite_bvalid  (s_lite_bvalid),
        .s_lite_bresp   (s_lite_bresp),
        .s_lite_bready  (s_lite_bready),
        .s_lite_arvalid (s_lite_arvalid),
        .s_lite_araddr  (s_lite_araddr),
        .s_lite_arready (s_lite_arready),
        .s_lite_rvalid  (s_lite_rvalid),
        .s_lite_rdata   (s_lite_rdata),
        .s_lite_rresp   (s_lite_rresp),
        .s_lite_rready  (s_lite_rready),
        .action_start   (action_start),
        .action_done    (action_done),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Free-running cycle index plus an action_start monitor.
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int b_cyc = 0;
    int rd_ar_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (action_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    // Behavioural register model.
    logic [DW-1:0] m_scr [NR];
    logic          m_irq_en, m_busy, m_done;
    logic [DW-1:0] m_cycles;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_scr[i] = '0;
        m_irq_en = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_cycles = '0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, output logic [1:0] resp);
        bit aw_done, w_done, got;
        aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
        s_lite_awaddr = a; s_lite_awvalid = 1'b1;
        s_lite_wdata = d; s_lite_wstrb = s; s_lite_wvalid = 1'b1;
        s_lite_bready = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (s_lite_awvalid && s_lite_awready) aw_done = 1;
            if (s_lite_wvalid && s_lite_wready) w_done = 1;
            if (s_lite_bvalid) begin
                got = 1; resp = s_lite_bresp; b_cyc = cyc;
            end
            @(posedge clk); #1;
            if (aw_done) s_lite_awvalid = 1'b0;
            if (w_done) s_lite_wvalid = 1'b0;
        end
        s_lite_awvalid = 1'b0; s_lite_wvalid = 1'b0; s_lite_bready = 1'b0;
        check("b_handshake", got, 1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp);
        bit acc, got;
        acc = 0; got = 0; d = '0; resp = 2'b11;
        s_lite_araddr = a; s_lite_arvalid = 1'b1; s_lite_rready = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (s_lite_arvalid && s_lite_arready) begin
                acc = 1; rd_ar_cyc = cyc;
            end
            if (s_lite_rvalid) begin
                got = 1; d = s_lite_rdata; resp = s_lite_rresp;
            end
            @(posedge clk); #1;
            if (acc) s_lite_arvalid = 1'b0;
        end
        s_lite_arvalid = 1'b0; s_lite_rready = 1'b0;
        check("r_handshake", got, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        logic [1:0]  resp;
        int unsigned idx;
        bit          oor;
        idx = a >> 2;
        oor = idx >= NR;
        axi_write(a, d, s, resp);
        check($sformatf("bresp@%0h", a), resp, (oor || idx == 0) ? RESP_SLVERR : RESP_OKAY);
        if (!oor) begin
            if (idx == 1 && s[0]) begin
                m_irq_en = d[1];
                if (d[0]) m_busy = 1'b1;
            end else if (idx >= 4) begin
                for (int b = 0; b < SW; b++)
                    if (s[b]) m_scr[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        logic [DW-1:0] d, exp;
        logic [1:0]    resp;
        int unsigned   idx;
        bit            oor;
        idx = a >> 2;
        oor = idx >= NR;
        axi_read(a, d, resp);
        exp = '0;
        if (!oor) begin
            case (idx)
                0: exp = DW'(ID);
                1: exp[1] = m_irq_en;
                2: begin exp[0] = m_busy; exp[1] = m_done; end
                3: exp = m_busy ? DW'(rd_ar_cyc - start_cyc) : m_cycles;
                default: exp = m_scr[idx];
            endcase
        end
        check($sformatf("rdata@%0h", a), d, exp);
        check($sformatf("rresp@%0h", a), resp, oor ? RESP_SLVERR : RESP_OKAY);
        if (!oor && idx == 2) m_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        int            idx, done_cyc;
        bit            seen;

        s_lite_awvalid = 0; s_lite_awaddr = '0; s_lite_wvalid = 0; s_lite_wdata = '0;
        s_lite_wstrb = '0; s_lite_bready = 0; s_lite_arvalid = 0; s_lite_araddr = '0;
        s_lite_rready = 0; action_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_awready", s_lite_awready, 1);
        check("rst_wready", s_lite_wready, 1);
        check("rst_arready", s_lite_arready, 1);
        check("rst_bvalid", s_lite_bvalid, 0);
        check("rst_rvalid", s_lite_rvalid, 0);
        check("rst_start", action_start, 0);
        check("rst_irq", irq, 0);
        check("rst_bresp", s_lite_bresp, 0);
        check("rst_rresp", s_lite_rresp, 0);
        check("rst_rdata", s_lite_rdata, 0);
        @(posedge clk); #1;

        // Byte-strobed write and ID read
        do_write(5*4, 32'hDEAD_BEEF, 4'b0101);
        do_read(5*4);
        do_read(0);

        // W three cycles ahead of AW, B held off
        s_lite_wdata = 32'h1234_5678; s_lite_wstrb = '1; s_lite_wvalid = 1; s_lite_bready = 0;
        @(negedge clk); check("wearly_wready", s_lite_wready, 1);
        @(posedge clk); #1; s_lite_wvalid = 0;
        @(negedge clk); check("wheld_wready", s_lite_wready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_lite_awaddr = 6*4; s_lite_awvalid = 1;
        @(negedge clk);
        check("wearly_awready", s_lite_awready, 1);
        check("wearly_bvalid0", s_lite_bvalid, 0);
        @(posedge clk); #1; s_lite_awvalid = 0;
        @(negedge clk); check("wearly_bvalid1", s_lite_bvalid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("wearly_bvalid2", s_lite_bvalid, 1);
        check("wearly_bresp", s_lite_bresp, RESP_OKAY);
        check("bpend_awready", s_lite_awready, 0);
        check("bpend_wready", s_lite_wready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bhold_bvalid", s_lite_bvalid, 1);
        check("bhold_awready", s_lite_awready, 0);
        @(posedge clk); #1; s_lite_bready = 1;
        @(posedge clk); #1; s_lite_bready = 0;
        @(negedge clk);
        check("bdone_bvalid", s_lite_bvalid, 0);
        check("bdone_awready", s_lite_awready, 1);
        check("bdone_wready", s_lite_wready, 1);
        m_scr[6] = 32'h1234_5678;
        @(posedge clk); #1;
        do_read(6*4);

        // Start / done handshake, CYCLES, irq, clear-on-read
        start_cnt = 0;
        do_write(1*4, 32'h3, 4'hF);
        check("start_pulses", start_cnt, 1);
        check("start_with_update", start_cyc, b_cyc);
        while (cyc < start_cyc + 9) begin @(posedge clk); #1; end
        done_cyc = cyc;
        action_done = 1; @(posedge clk); #1; action_done = 0;
        m_busy = 0; m_done = 1;
        m_cycles = DW'(done_cyc - start_cyc + 1);
        do_read(3*4);
        @(negedge clk); check("irq_set", irq, 1);
        @(posedge clk); #1;
        do_read(2*4);
        @(negedge clk); check("irq_lag", irq, 1);
        @(posedge clk); #1;
        @(negedge clk); check("irq_clear", irq, 0);
        @(posedge clk); #1;
        do_read(2*4);
        do_read(1*4);

        // Out-of-range and read-only ID
        do_read(NR*4);
        do_read(32'h8000_0010);
        do_write(0, 32'hFFFF_FFFF, 4'hF);
        do_read(0);

        // Read data held while rready is low
        wd = $urandom;
        do_write(7*4, wd, 4'hF);
        s_lite_araddr = 7*4; s_lite_arvalid = 1; s_lite_rready = 0;
        @(negedge clk); check("stall_ar_acc", s_lite_arready, 1);
        @(posedge clk); #1; s_lite_arvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_rvalid", s_lite_rvalid, 1);
            check("stall_rdata", s_lite_rdata, m_scr[7]);
            check("stall_arready", s_lite_arready, 0);
            @(posedge clk); #1;
        end
        s_lite_rready = 1; @(posedge clk); #1; s_lite_rready = 0;
        @(negedge clk); check("stall_rvalid_drop", s_lite_rvalid, 0);
        @(posedge clk); #1;

        // Re-start while busy restarts CYCLES
        do_write(1*4, 32'h3, 4'hF);
        repeat (4) @(posedge clk); #1;
        do_write(1*4, 32'h3, 4'hF);
        check("restart_pulses", start_cnt, 3);
        do_read(3*4);

        // action_done coincident with the clear-on-read R accept
        s_lite_araddr = 2*4; s_lite_arvalid = 1; s_lite_rready = 0;
        @(posedge clk); #1; s_lite_arvalid = 0;
        @(negedge clk);
        check("coinc_rvalid", s_lite_rvalid, 1);
        check("coinc_rdata", s_lite_rdata, {30'b0, m_done, m_busy});
        @(posedge clk); #1;
        s_lite_rready = 1; action_done = 1; done_cyc = cyc;
        @(posedge clk); #1;
        s_lite_rready = 0; action_done = 0;
        m_busy = 0; m_done = 1; m_cycles = DW'(done_cyc - start_cyc + 1);
        do_read(2*4);
        do_read(2*4);
        do_read(3*4);

        // Randomized scratch / ID / out-of-range traffic
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(4, NR + 3);
            if ($urandom_range(0, 5) == 0) idx = 0;
            ra = AW'(idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(8, 31));
            if ($urandom_range(0, 1) == 0) do_write(ra, $urandom, SW'($urandom_range(0, 15)));
            else                           do_read(ra);
        end
        for (int i = 4; i < NR; i++) do_read(AW'(i * 4));

        // Reset while a B response is pending
        s_lite_awaddr = 5*4; s_lite_awvalid = 1;
        s_lite_wdata = $urandom | 32'h1; s_lite_wstrb = '1; s_lite_wvalid = 1; s_lite_bready = 0;
        @(posedge clk); #1; s_lite_awvalid = 0; s_lite_wvalid = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk); seen = s_lite_bvalid;
            @(posedge clk); #1;
        end
        check("rstmid_bpending", seen, 1);
        rst_n = 0;
        model_reset();
        @(negedge clk); check("rstmid_bvalid_in_reset", s_lite_bvalid, 0);
        repeat (2) @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        check("rstmid_bvalid", s_lite_bvalid, 0);
        check("rstmid_awready", s_lite_awready, 1);
        check("rstmid_wready", s_lite_wready, 1);
        check("rstmid_arready", s_lite_arready, 1);
        check("rstmid_irq", irq, 0);
        @(posedge clk); #1;
        do_read(5*4);
        do_read(6*4);
        do_read(1*4);
        do_read(2*4);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
